// File: rtl/vector_recorder_pkg.sv
// Shared types for the vector recorder. VECTOR_RECORDER_TIMESTAMP_EN adds a
// 16-bit capture timestamp to every stored entry.
package vector_recorder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } vrec_state_t;

  localparam int TS_W = 16;

`ifdef VECTOR_RECORDER_TIMESTAMP_EN
  localparam int TS_EXTRA = TS_W;
`else
  localparam int TS_EXTRA = 0;
`endif

endpackage

// File: rtl/vector_recorder_mem.sv
// Entry buffer for the vector recorder: flop array, one synchronous write
// port and one combinational read port. Contents are intentionally not reset.
module vrec_mem #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 4
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [ENTRY_W-1:0]       wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [ENTRY_W-1:0]       rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vector_recorder.sv
// Records WIDTH-bit samples into a buffer, then plays them back over a
// valid/ready port. VECTOR_RECORDER_TIMESTAMP_EN prefixes each entry with a 16-bit cycle stamp.
module vector_recorder
  import vector_recorder_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         arm,
  input  logic                         stop,
  input  logic                         sample_valid,
  input  logic [WIDTH-1:0]             sample,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [WIDTH+TS_EXTRA-1:0]    rd_data,
  output logic                         rd_last,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy,
  output logic                         overflow,
  output logic                         done
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = $clog2(DEPTH+1);
  localparam int ENTRY_W = WIDTH + TS_EXTRA;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Playback handshake: an entry transfers on a cycle where rd_valid && rd_ready;
  // rd_data/rd_last hold steady while rd_valid && !rd_ready.

  vrec_state_t       state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic              overflow_q, overflow_d;
  logic              wr_en;
  logic [ENTRY_W-1:0] wr_data;

  // rd_cnt is one bit wider than the read pointer so a full drain compares cleanly with count.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_cnt_d   = rd_cnt_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    rd_valid   = 1'b0;
    rd_last    = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d    = CAPTURE;
          count_d    = '0;
          wr_ptr_d   = '0;
          rd_cnt_d   = '0;
          overflow_d = 1'b0;
        end
      end
      CAPTURE: begin
        if (sample_valid) begin
          if (count_q != FULL) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_q + CW'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (stop || (count_q == FULL)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        rd_valid = (rd_cnt_q != count_q);
        rd_last  = rd_valid && (rd_cnt_q == count_q - CW'(1));
        if (!rd_valid) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (rd_ready) begin
          rd_cnt_d = rd_cnt_q + CW'(1);
          if (rd_last) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_cnt_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_cnt_q   <= rd_cnt_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef VECTOR_RECORDER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  always_comb begin
    ts_d = ts_q;
    if ((state_q == IDLE) && arm) begin
      ts_d = '0;
    end else if (state_q == CAPTURE) begin
      ts_d = ts_q + TS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  assign wr_data = {ts_q, sample};
`else
  assign wr_data = sample;
`endif

  vrec_mem #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_cnt_q[AW-1:0]),
    .rdata_o (rd_data)
  );

  assign count    = count_q;
  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;

endmodule
